// File: rtl/msrh_lsu_pkg.sv
// Shared LSU types for the store-buffer issue path: line-request entry, access size, strobe helper.
package msrh_lsu_pkg;

  localparam int unsigned ST_BUF_WIDTH = 128;
  localparam int unsigned PADDR_W      = 40;
  localparam int unsigned XLEN_W       = 64;
  localparam int unsigned SB_B         = ST_BUF_WIDTH / 8;
  localparam int unsigned SB_OFF_W     = $clog2(SB_B);

  typedef enum logic [1:0] {
    SizeB = 2'd0,
    SizeH = 2'd1,
    SizeW = 2'd2,
    SizeD = 2'd3
  } mem_size_t;

  typedef struct packed {
    logic [PADDR_W-1:0]      paddr;
    logic [SB_B-1:0]         strb;
    logic [ST_BUF_WIDTH-1:0] data;
  } stbuf_issue_entry_t;

  function automatic logic [SB_B-1:0] gen_line_strb(input logic [SB_OFF_W-1:0] off,
                                                    input mem_size_t size);
    logic [SB_B-1:0] base;
    unique case (size)
      SizeB:   base = SB_B'(8'h01);
      SizeH:   base = SB_B'(8'h03);
      SizeW:   base = SB_B'(8'h0f);
      default: base = SB_B'(8'hff);
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/msrh_stbuf_issue_align.sv
// Places a right-justified store into its byte lanes of a store-buffer line request.
module msrh_stbuf_issue_align
  import msrh_lsu_pkg::*;
(
  input  logic [PADDR_W-1:0] paddr_i,
  input  logic [1:0]         size_i,
  input  logic [XLEN_W-1:0]  data_i,
  output stbuf_issue_entry_t entry_o
);

  logic [SB_OFF_W-1:0]     off;
  logic [ST_BUF_WIDTH-1:0] data_wide;

  assign off       = paddr_i[SB_OFF_W-1:0];
  assign data_wide = ST_BUF_WIDTH'(data_i);

  always_comb begin
    entry_o       = '0;
    entry_o.paddr = {paddr_i[PADDR_W-1:SB_OFF_W], {SB_OFF_W{1'b0}}};
    entry_o.strb  = gen_line_strb(off, mem_size_t'(size_i));
    entry_o.data  = data_wide << {off, 3'b000};
  end

endmodule

// File: rtl/msrh_stbuf_issue.sv
// In-order store-buffer request FIFO fed by the STQ commit port.
// Define MSRH_STBUF_ISSUE_COALESCE_EN to merge same-line stores into the tail entry.
module msrh_stbuf_issue
  import msrh_lsu_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ST_BUF_WIDTH = msrh_lsu_pkg::ST_BUF_WIDTH,
  parameter int unsigned PADDR_W      = msrh_lsu_pkg::PADDR_W,
  parameter int unsigned XLEN_W       = msrh_lsu_pkg::XLEN_W
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_commit_valid,
  output logic                      o_commit_ready,
  input  logic [PADDR_W-1:0]        i_commit_paddr,
  input  logic [1:0]                i_commit_size,
  input  logic [XLEN_W-1:0]         i_commit_data,
  output logic                      o_stbuf_valid,
  output logic [PADDR_W-1:0]        o_stbuf_paddr,
  output logic [ST_BUF_WIDTH/8-1:0] o_stbuf_strb,
  output logic [ST_BUF_WIDTH-1:0]   o_stbuf_data,
  input  logic                      i_stbuf_accept,
  output logic                      o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  stbuf_issue_entry_t mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tail_ptr;
  logic [CntW-1:0]    count_q, count_d;

  stbuf_issue_entry_t aligned, merged, wr_entry;
  logic               push, pop, merge, alloc;
  logic [PtrW-1:0]    wr_idx;

  msrh_stbuf_issue_align u_align (
    .paddr_i (i_commit_paddr),
    .size_i  (i_commit_size),
    .data_i  (i_commit_data),
    .entry_o (aligned)
  );

  assign o_commit_ready = (count_q < CntW'(DEPTH));
  assign o_stbuf_valid  = (count_q != '0);
  assign o_empty        = (count_q == '0);

  assign push     = i_commit_valid & o_commit_ready;
  assign pop      = o_stbuf_valid & i_stbuf_accept;
  assign tail_ptr = wr_ptr_q - PtrW'(1);

`ifdef MSRH_STBUF_ISSUE_COALESCE_EN
  assign merge = push && (count_q >= CntW'(2)) && !(pop && (tail_ptr == rd_ptr_q)) &&
                 (mem_q[tail_ptr].paddr == aligned.paddr);
`else
  assign merge = 1'b0;
`endif
  assign alloc = push & ~merge;

  // Newer store wins on overlapping bytes.
  always_comb begin
    merged      = mem_q[tail_ptr];
    merged.strb = merged.strb | aligned.strb;
    for (int i = 0; i < int'(SB_B); i++) begin
      if (aligned.strb[i]) merged.data[8*i +: 8] = aligned.data[8*i +: 8];
    end
  end

  assign wr_entry = merge ? merged : aligned;
  assign wr_idx   = merge ? tail_ptr : wr_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (alloc ? PtrW'(1) : PtrW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? PtrW'(1) : PtrW'(0));
    count_d  = count_q;
    if (alloc && !pop)      count_d = count_q + CntW'(1);
    else if (!alloc && pop) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && push) mem_q[wr_idx] <= wr_entry;
  end

  assign o_stbuf_paddr = mem_q[rd_ptr_q].paddr;
  assign o_stbuf_strb  = mem_q[rd_ptr_q].strb;
  assign o_stbuf_data  = mem_q[rd_ptr_q].data;

  // The STQ only commits naturally aligned stores, so none may straddle a line.
  logic [SB_OFF_W:0] end_byte;
  assign end_byte = {1'b0, i_commit_paddr[SB_OFF_W-1:0]} + ((SB_OFF_W+1)'(1) << i_commit_size);

  a_no_line_cross: assert property (@(posedge i_clk) disable iff (i_reset)
    i_commit_valid |-> (end_byte <= (SB_OFF_W+1)'(SB_B)));

endmodule
